// File: rtl/uart_bit_rx_if.sv
// uart_bit_rx_if: serial-line and received-byte signals of the bit-level UART
// receiver. The master drives the line and back-pressure; the slave (the
// receiver) returns the byte and the status pulses.
interface uart_bit_rx_if;
    logic       Rx;
    logic       Rdyn;
    logic [7:0] Data;
    logic       DataValid;
    logic       FrameErr;
    logic       ParityErr;
    logic       Overrun;

    modport master (
        output Rx, Rdyn,
        input  Data, DataValid, FrameErr, ParityErr, Overrun
    );

    modport slave (
        input  Rx, Rdyn,
        output Data, DataValid, FrameErr, ParityErr, Overrun
    );
endinterface

// File: rtl/uart_bit_rx.sv
// uart_bit_rx: oversampling bit-level UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to add a parity bit (8E1 / 8O1 via PARITY_ODD).
// Emits one DataValid pulse per good byte plus FrameErr / ParityErr / Overrun
// status pulses. All pulses are registered and last exactly one Clk cycle.
module uart_bit_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2,
    parameter int PARITY_ODD   = 0
) (
    input  logic         Clk,
    input  logic         ARst,
    uart_bit_rx_if.slave bus
);

    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF   = CW'((CLKS_PER_BIT - 1) / 2);

    // Reject configurations the counter and synchroniser cannot support.
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_bit_rx: CLKS_PER_BIT out of range 4..65535");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_bit_rx: SYNC_STAGES must be at least 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_bit_rx: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   w_tick;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_dv;
    logic                   r_fe;
    logic                   r_ov;
    logic                   w_par_ok;

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) r_sync <= '1;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.Rx};
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_pe;
    assign w_par_ok      = ((^r_shift) ^ PARITY_ODD[0]) == r_par;
    assign bus.ParityErr = r_pe;
`else
    assign w_par_ok      = 1'b1;
    assign bus.ParityErr = 1'b0;
`endif

    // Frame FSM with baud down-counter, shift register and registered pulses.
    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
            r_ov    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_pe    <= 1'b0;
`endif
        end else begin
            r_dv <= 1'b0;
            r_fe <= 1'b0;
            r_ov <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe <= 1'b0;
`endif
            // Free-running baud count while inside a frame.
            if (r_state != S_IDLE && r_state != S_BREAK)
                r_cnt <= w_tick ? RELOAD : r_cnt - CW'(1);

            case (r_state)
                S_IDLE: begin
                    // Half-bit load so later ticks land mid-bit.
                    if (!w_rx_s) begin
                        r_cnt   <= HALF;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_par   <= w_rx_s;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Going straight to IDLE here catches a start bit that
                    // follows only half a bit-time after the mid-stop sample.
                    if (w_tick) begin
                        r_state <= w_rx_s ? S_IDLE : S_BREAK;
                        if (!w_rx_s) begin
                            r_fe <= 1'b1;
                        end else if (w_par_ok) begin
                            if (bus.Rdyn) begin
                                r_ov <= 1'b1;
                            end else begin
                                r_data <= r_shift;
                                r_dv   <= 1'b1;
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        r_pe <= !w_par_ok;
`endif
                    end
                end
                S_BREAK: begin
                    // A stuck-low line gives only one FrameErr.
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Data      = r_data;
    assign bus.DataValid = r_dv;
    assign bus.FrameErr  = r_fe;
    assign bus.Overrun   = r_ov;

endmodule

// File: tb/tb_uart_bit_rx.sv
// tb_uart_bit_rx: directed plus random frames against a frame-level reference
// model (expected event list per transmitted character). Build with
// UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_bit_rx;

    localparam int C    = 16;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    localparam int EV_DV = 1;
    localparam int EV_FE = 2;
    localparam int EV_PE = 3;
    localparam int EV_OV = 4;

    logic Clk = 1'b0;
    logic ARst;
    uart_bit_rx_if bus();

    uart_bit_rx #(
        .CLKS_PER_BIT(C),
        .SYNC_STAGES (2),
        .PARITY_ODD  (int'(PODD))
    ) dut (
        .Clk (Clk),
        .ARst(ARst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_k[$], exp_d[$], obs_k[$], obs_d[$];
    logic [7:0] model_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every pulse the DUT emits, sampled away from the active edge.
    always @(negedge Clk) begin
        if (bus.DataValid) begin obs_k.push_back(EV_DV); obs_d.push_back(int'(bus.Data)); end
        if (bus.FrameErr)  begin obs_k.push_back(EV_FE); obs_d.push_back(0); end
        if (bus.ParityErr) begin obs_k.push_back(EV_PE); obs_d.push_back(0); end
        if (bus.Overrun)   begin obs_k.push_back(EV_OV); obs_d.push_back(0); end
    end

    // Reference: outcome of one character from its stop level, parity and Rdyn.
    task automatic model(input logic [7:0] b, input bit stop_hi, input bit par_bad, input bit rdyn);
        bit pb;
        pb = par_bad && PAR_ON;
        if (!stop_hi) begin
            exp_k.push_back(EV_FE); exp_d.push_back(0);
            if (pb) begin exp_k.push_back(EV_PE); exp_d.push_back(0); end
        end else if (pb) begin
            exp_k.push_back(EV_PE); exp_d.push_back(0);
        end else if (rdyn) begin
            exp_k.push_back(EV_OV); exp_d.push_back(0);
        end else begin
            exp_k.push_back(EV_DV); exp_d.push_back(int'(b));
            model_data = b;
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.Rx = v;
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_hi, input bit par_bad, input int stop_len);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(b[i], C);
        if (PAR_ON) drive((^b) ^ PODD ^ par_bad, C);
        drive(stop_hi, stop_len);
    endtask

    task automatic txchar(input logic [7:0] b, input bit stop_hi, input bit par_bad, input bit rdyn, input int gap);
        bus.Rdyn = rdyn;
        model(b, stop_hi, par_bad, rdyn);
        send_frame(b, stop_hi, par_bad, C);
        bus.Rdyn = 1'b0;
        drive(1'b1, gap);
    endtask

    task automatic check_events(input string tag);
        int n;
        repeat (2 * C) @(negedge Clk);
        chk({tag, "/count"}, obs_k.size(), exp_k.size());
        n = (obs_k.size() < exp_k.size()) ? obs_k.size() : exp_k.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/kind%0d", tag, i), obs_k[i], exp_k[i]);
            chk($sformatf("%s/data%0d", tag, i), obs_d[i], exp_d[i]);
        end
        chk({tag, "/held"}, bus.Data, model_data);
        obs_k.delete(); obs_d.delete(); exp_k.delete(); exp_d.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/Data"}, bus.Data, 8'h00);
        chk({tag, "/DV"},   bus.DataValid, 1'b0);
        chk({tag, "/FE"},   bus.FrameErr, 1'b0);
        chk({tag, "/PE"},   bus.ParityErr, 1'b0);
        chk({tag, "/OV"},   bus.Overrun, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        ARst = 1'b1; bus.Rx = 1'b1; bus.Rdyn = 1'b0;
        repeat (3) @(negedge Clk);
        chk_zero("reset");
        ARst = 1'b0;
        drive(1'b1, 2 * C);

        // Single clean byte.
        txchar(8'hA5, 1'b1, 1'b0, 1'b0, C);
        check_events("a5");

        // Back-to-back: stop just over half a bit, enough to clear the
        // mid-stop sample which lags the line by the synchroniser depth.
        model(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0, C / 2 + 4);
        txchar(8'hFF, 1'b1, 1'b0, 1'b0, C);
        check_events("b2b");

        // Short glitch: no pulse, and the receiver must still be idle.
        drive(1'b0, 4);
        drive(1'b1, 2 * C);
        check_events("glitch");
        txchar(8'h96, 1'b1, 1'b0, 1'b0, C);
        check_events("post_glitch");

        // Stop low then a long break: exactly one FrameErr.
        model(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, C);
        drive(1'b0, 20 * C);
        drive(1'b1, 2 * C);
        txchar(8'h11, 1'b1, 1'b0, 1'b0, C);
        check_events("break");

        // Downstream busy: byte dropped, Data keeps 8'h11.
        txchar(8'h5A, 1'b1, 1'b0, 1'b1, C);
        check_events("overrun");

        if (PAR_ON) begin
            txchar(8'h01, 1'b1, 1'b0, 1'b0, C);
            txchar(8'h01, 1'b1, 1'b1, 1'b0, C);
            check_events("parity");
        end

        // Reset in the middle of data bit 3 of 8'hC3.
        rb = 8'hC3;
        drive(1'b0, C);
        for (int i = 0; i < 3; i++) drive(rb[i], C);
        drive(rb[3], C / 2);
        ARst = 1'b1;
        @(negedge Clk);
        chk_zero("arst");
        repeat (2) @(negedge Clk);
        ARst = 1'b0;
        model_data = 8'h00;
        obs_k.delete(); obs_d.delete();
        drive(1'b1, 2 * C);
        check_events("arst_quiet");
        txchar(8'h7E, 1'b1, 1'b0, 1'b0, C);
        check_events("after_arst");

        // Random traffic.
        for (int i = 0; i < 30; i++) begin
            txchar(8'($urandom),
                   $urandom_range(0, 9) != 0,
                   $urandom_range(0, 6) == 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(4, 2 * C));
        end
        check_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
